exme_pipe_reg: RTL and testbench

EXME_PIPE_REG -- requirements
Module: exme_pipe_reg

---
 rtl/exme_pipe_reg.sv | 165 ++++++++++++++++
 tb/tb_exme_pipe_reg.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exme_pipe_reg.sv
// exme_pipe_reg: EX/MEM pipeline register with a single-entry valid/ready
// handshake.
//
// An instruction from EX is captured when the stage is ready, and is held
// while MEM stalls. A flush kills both the held entry and any incoming one.
// Bubbles and flushes clear only the stored write enables. The payload
// registers keep their last value in those cases, because the gated
// regWrtm/memWrtm outputs already make the stale payload harmless.
//
// Optional feature: define EXME_PIPE_PERF_EN to build the stall/bubble
// performance counters. When the macro is undefined, both counter ports
// read as zero and no counter flops exist.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   validE / readyE                   EX-side handshake
//   flushM                            kill held and incoming instruction
//   regWrte, memWrte, rsltSrce,
//   aluRslte, wrtDe, pc4e, ujWrtBcke,
//   rde                               EX control and payload
//   validM / readyM                   MEM-side handshake
//   regWrtm, memWrtm                  stored write enables, gated by validM
//   rsltSrcm, aluRsltm, wrtDm, pc4m,
//   ujWrtBckm, rdm                    registered control and payload
//   stallCnt, bubbleCnt               saturating performance counters
module exme_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int RSLT_W  = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               validE,
  output logic               readyE,
  input  logic               flushM,
  input  logic               regWrte,
  input  logic               memWrte,
  input  logic [RSLT_W-1:0]  rsltSrce,
  input  logic [XLEN-1:0]    aluRslte,
  input  logic [XLEN-1:0]    wrtDe,
  input  logic [XLEN-1:0]    pc4e,
  input  logic [XLEN-1:0]    ujWrtBcke,
  input  logic [RADDR_W-1:0] rde,
  output logic               validM,
  input  logic               readyM,
  output logic               regWrtm,
  output logic               memWrtm,
  output logic [RSLT_W-1:0]  rsltSrcm,
  output logic [XLEN-1:0]    aluRsltm,
  output logic [XLEN-1:0]    wrtDm,
  output logic [XLEN-1:0]    pc4m,
  output logic [XLEN-1:0]    ujWrtBckm,
  output logic [RADDR_W-1:0] rdm,
  output logic [CNT_W-1:0]   stallCnt,
  output logic [CNT_W-1:0]   bubbleCnt
);

  logic               valid_q,     valid_d;
  logic               reg_wrt_q,   reg_wrt_d;
  logic               mem_wrt_q,   mem_wrt_d;
  logic [RSLT_W-1:0]  rslt_src_q,  rslt_src_d;
  logic [XLEN-1:0]    alu_rslt_q,  alu_rslt_d;
  logic [XLEN-1:0]    wrt_data_q,  wrt_data_d;
  logic [XLEN-1:0]    pc4_q,       pc4_d;
  logic [XLEN-1:0]    uj_wrt_bk_q, uj_wrt_bk_d;
  logic [RADDR_W-1:0] rd_q,        rd_d;

  // The slot can take a new entry when it is empty or is being drained.
  assign readyE = !valid_q || readyM;

  always_comb begin
    valid_d     = valid_q;
    reg_wrt_d   = reg_wrt_q;
    mem_wrt_d   = mem_wrt_q;
    rslt_src_d  = rslt_src_q;
    alu_rslt_d  = alu_rslt_q;
    wrt_data_d  = wrt_data_q;
    pc4_d       = pc4_q;
    uj_wrt_bk_d = uj_wrt_bk_q;
    rd_d        = rd_q;
    if (flushM) begin
      valid_d   = 1'b0;
      reg_wrt_d = 1'b0;
      mem_wrt_d = 1'b0;
    end else if (readyE) begin
      if (validE) begin
        valid_d     = 1'b1;
        reg_wrt_d   = regWrte;
        mem_wrt_d   = memWrte;
        rslt_src_d  = rsltSrce;
        alu_rslt_d  = aluRslte;
        wrt_data_d  = wrtDe;
        pc4_d       = pc4e;
        uj_wrt_bk_d = ujWrtBcke;
        rd_d        = rde;
      end else begin
        valid_d   = 1'b0;
        reg_wrt_d = 1'b0;
        mem_wrt_d = 1'b0;
      end
    end
    // Otherwise MEM is stalling a valid entry: every register holds.
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_wrt_q   <= 1'b0;
      mem_wrt_q   <= 1'b0;
      rslt_src_q  <= '0;
      alu_rslt_q  <= '0;
      wrt_data_q  <= '0;
      pc4_q       <= '0;
      uj_wrt_bk_q <= '0;
      rd_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_wrt_q   <= reg_wrt_d;
      mem_wrt_q   <= mem_wrt_d;
      rslt_src_q  <= rslt_src_d;
      alu_rslt_q  <= alu_rslt_d;
      wrt_data_q  <= wrt_data_d;
      pc4_q       <= pc4_d;
      uj_wrt_bk_q <= uj_wrt_bk_d;
      rd_q        <= rd_d;
    end
  end

  assign validM    = valid_q;
  assign regWrtm   = reg_wrt_q && valid_q;
  assign memWrtm   = mem_wrt_q && valid_q;
  assign rsltSrcm  = rslt_src_q;
  assign aluRsltm  = alu_rslt_q;
  assign wrtDm     = wrt_data_q;
  assign pc4m      = pc4_q;
  assign ujWrtBckm = uj_wrt_bk_q;
  assign rdm       = rd_q;

`ifdef EXME_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Both counters saturate at all-ones instead of wrapping. A flush does
  // not reset them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (valid_q && !readyM && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (!valid_q && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign stallCnt  = stall_cnt_q;
  assign bubbleCnt = bubble_cnt_q;
`else
  assign stallCnt  = '0;
  assign bubbleCnt = '0;
`endif

endmodule

// File: tb/tb_exme_pipe_reg.sv
module tb_exme_pipe_reg;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int RSLT_W  = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, validE, readyE, flushM, regWrte, memWrte;
  logic [RSLT_W-1:0]  rsltSrce, rsltSrcm;
  logic [XLEN-1:0]    aluRslte, wrtDe, pc4e, ujWrtBcke;
  logic [XLEN-1:0]    aluRsltm, wrtDm, pc4m, ujWrtBckm;
  logic [RADDR_W-1:0] rde, rdm;
  logic               validM, readyM, regWrtm, memWrtm;
  logic [CNT_W-1:0]   stallCnt, bubbleCnt;

  exme_pipe_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .RSLT_W(RSLT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .validE(validE), .readyE(readyE), .flushM(flushM),
    .regWrte(regWrte), .memWrte(memWrte), .rsltSrce(rsltSrce), .aluRslte(aluRslte),
    .wrtDe(wrtDe), .pc4e(pc4e), .ujWrtBcke(ujWrtBcke), .rde(rde),
    .validM(validM), .readyM(readyM), .regWrtm(regWrtm), .memWrtm(memWrtm),
    .rsltSrcm(rsltSrcm), .aluRsltm(aluRsltm), .wrtDm(wrtDm), .pc4m(pc4m),
    .ujWrtBckm(ujWrtBckm), .rdm(rdm), .stallCnt(stallCnt), .bubbleCnt(bubbleCnt)
  );

  typedef struct packed {
    logic               rw;
    logic               mw;
    logic [RSLT_W-1:0]  rs;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    wd;
    logic [XLEN-1:0]    pc4;
    logic [XLEN-1:0]    uj;
    logic [RADDR_W-1:0] rd;
  } ent_t;

  localparam int VW = 5 + RSLT_W + 4 * XLEN + RADDR_W - 2;

  // Model: a queue of at most one in-flight instruction, plus the last
  // instruction ever accepted (what the payload outputs show).
  ent_t pend[$];
  ent_t last;
  int   m_stall, m_bubble;
  logic ready_pre, exp_ready_pre;
  int   checks = 0;
  int   failures = 0;

  logic [VW-1:0] act_vec;
  assign act_vec = {validM, regWrtm, memWrtm, rsltSrcm, aluRsltm, wrtDm, pc4m, ujWrtBckm, rdm};

  function automatic logic [VW-1:0] exp_vec();
    logic v;
    v = (pend.size() != 0);
    return {v, v & last.rw, v & last.mw, last.rs, last.alu, last.wd, last.pc4, last.uj, last.rd};
  endfunction

  function automatic logic [CNT_W-1:0] exp_stall();
`ifdef EXME_PIPE_PERF_EN
    return CNT_W'(m_stall);
`else
    return '0;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] exp_bubble();
`ifdef EXME_PIPE_PERF_EN
    return CNT_W'(m_bubble);
`else
    return '0;
`endif
  endfunction

  // Advance one clock: settle, sample readyE, update model, clock, settle.
  task automatic cycle();
    ent_t inc;
    bit   full;
    #1;
    ready_pre     = readyE;
    full          = (pend.size() != 0);
    exp_ready_pre = !full || readyM;
    inc = {regWrte, memWrte, rsltSrce, aluRslte, wrtDe, pc4e, ujWrtBcke, rde};
    if (rst) begin
      pend.delete();
      last     = '0;
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (full && !readyM && m_stall < CNT_MAX) m_stall++;
      if (!full && m_bubble < CNT_MAX) m_bubble++;
      if (flushM) pend.delete();
      else if (exp_ready_pre) begin
        if (full) void'(pend.pop_front());
        if (validE) begin
          pend.push_back(inc);
          last = inc;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; validE = 1'b0; flushM = 1'b0; readyM = 1'b1;
    regWrte = 1'b0; memWrte = 1'b0; rsltSrce = '0;
    aluRslte = '0; wrtDe = '0; pc4e = '0; ujWrtBcke = '0; rde = '0;
  endtask

  task automatic rand_payload();
    regWrte   = 1'($urandom);
    memWrte   = 1'($urandom);
    rsltSrce  = RSLT_W'($urandom);
    aluRslte  = $urandom;
    wrtDe     = $urandom;
    pc4e      = $urandom;
    ujWrtBcke = $urandom;
    rde       = RADDR_W'($urandom);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; validE = 1'b1; regWrte = 1'b1; rde = 5'd5; aluRslte = 32'hDEAD;
    cycle();
    cycle();
    checks++;
    if (validM !== 1'b0 || regWrtm !== 1'b0 || rdm !== '0 || aluRsltm !== '0) begin
      failures++;
      $display("FAIL reset_state: validM=%b regWrtm=%b rdm=%0d alu=%h expected 0 0 0 0",
               validM, regWrtm, rdm, aluRsltm);
    end
    checks++;
    if (stallCnt !== '0 || bubbleCnt !== '0) begin
      failures++;
      $display("FAIL reset_counters: stall=%0d bubble=%0d expected 0 0", stallCnt, bubbleCnt);
    end
    idle();
    cycle();
    checks++;
    if (ready_pre !== 1'b1) begin
      failures++;
      $display("FAIL reset_readyE: got %b expected 1", ready_pre);
    end
  endtask

  task automatic test_stream();
    idle();
    for (int i = 1; i <= 3; i++) begin
      validE = 1'b1; rand_payload(); aluRslte = 32'(i);
      cycle();
      checks++;
      if (aluRsltm !== 32'(i) || validM !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d: alu=%0d validM=%b expected alu=%0d validM=1", i, aluRsltm, validM, i);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL stream_model_%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    idle();
    validE = 1'b1; aluRslte = 32'hA5;
    cycle();
    readyM = 1'b0; aluRslte = 32'h5A;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (aluRsltm !== 32'hA5 || ready_pre !== 1'b0 || validM !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold_%0d: alu=%h readyE=%b validM=%b expected a5 0 1",
                 i, aluRsltm, ready_pre, validM);
      end
    end
    readyM = 1'b1;
    cycle();
    checks++;
    if (aluRsltm !== 32'h5A || ready_pre !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: alu=%h readyE=%b expected 5a 1", aluRsltm, ready_pre);
    end
  endtask

  task automatic test_flush();
    idle();
    validE = 1'b1; regWrte = 1'b1; memWrte = 1'b1; flushM = 1'b1;
    cycle();
    checks++;
    if (validM !== 1'b0 || regWrtm !== 1'b0 || memWrtm !== 1'b0) begin
      failures++;
      $display("FAIL flush_vs_accept: validM=%b regWrtm=%b memWrtm=%b expected 0 0 0",
               validM, regWrtm, memWrtm);
    end
    // Flush of a stalled entry.
    flushM = 1'b0;
    cycle();
    readyM = 1'b0; flushM = 1'b1;
    cycle();
    checks++;
    if (validM !== 1'b0 || regWrtm !== 1'b0 || memWrtm !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall: validM=%b regWrtm=%b memWrtm=%b expected 0 0 0",
               validM, regWrtm, memWrtm);
    end
    // Reset while stalled discards the entry.
    flushM = 1'b0; readyM = 1'b1; aluRslte = 32'h77;
    cycle();
    readyM = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (validM !== 1'b0 || aluRsltm !== '0) begin
      failures++;
      $display("FAIL reset_mid_stall: validM=%b alu=%h expected 0 0", validM, aluRsltm);
    end
    idle();
  endtask

  task automatic test_bubble();
    idle();
    validE = 1'b1; regWrte = 1'b1; rde = 5'd7;
    cycle();
    cycle();
    validE = 1'b0; rde = 5'd9;
    cycle();
    checks++;
    if (validM !== 1'b0 || regWrtm !== 1'b0 || rdm !== 5'd7) begin
      failures++;
      $display("FAIL bubble: validM=%b regWrtm=%b rdm=%0d expected 0 0 7", validM, regWrtm, rdm);
    end
    validE = 1'b1;
    cycle();
    checks++;
    if (validM !== 1'b1 || regWrtm !== 1'b1 || rdm !== 5'd9) begin
      failures++;
      $display("FAIL bubble_resume: validM=%b regWrtm=%b rdm=%0d expected 1 1 9", validM, regWrtm, rdm);
    end
  endtask

  task automatic test_counters();
    logic [CNT_W-1:0] want_stall, want_bubble;
`ifdef EXME_PIPE_PERF_EN
    want_stall = CNT_W'(CNT_MAX);
    want_bubble = CNT_W'(1);
`else
    want_stall = '0;
    want_bubble = '0;
`endif
    idle();
    rst = 1'b1;
    cycle();
    idle();
    validE = 1'b1;
    cycle();
    readyM = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if (stallCnt !== want_stall || bubbleCnt !== want_bubble) begin
      failures++;
      $display("FAIL counters_sat: stall=%0d bubble=%0d expected %0d %0d",
               stallCnt, bubbleCnt, want_stall, want_bubble);
    end
    cycle();
    checks++;
    if (stallCnt !== want_stall) begin
      failures++;
      $display("FAIL counters_hold: stall=%0d expected %0d", stallCnt, want_stall);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      rst    = ($urandom_range(0, 99) < 2);
      validE = ($urandom_range(0, 9) < 7);
      readyM = ($urandom_range(0, 9) < 7);
      flushM = ($urandom_range(0, 9) < 1);
      cycle();
      checks++;
      if (ready_pre !== exp_ready_pre) begin
        failures++;
        $display("FAIL rand_readyE_%0d: got %b expected %b", i, ready_pre, exp_ready_pre);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rand_outputs_%0d: got %h expected %h", i, act_vec, exp_vec());
      end
      checks++;
      if (stallCnt !== exp_stall() || bubbleCnt !== exp_bubble()) begin
        failures++;
        $display("FAIL rand_counters_%0d: stall=%0d bubble=%0d expected %0d %0d",
                 i, stallCnt, bubbleCnt, exp_stall(), exp_bubble());
      end
    end
  endtask

  initial begin
    last = '0;
    m_stall = 0;
    m_bubble = 0;
    idle();
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_counters();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
